// File: rtl/multdiv_pkg.sv
// Shared types and sizing helpers for the sequential multiply/divide unit.
package multdiv_pkg;

    localparam int unsigned WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_e;

    typedef enum logic {
        OP_MULT = 1'b0,
        OP_DIV  = 1'b1
    } op_e;

    // Iteration counter must hold the value WIDTH, hence log2(WIDTH)+1 bits.
    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/multdiv_dp.sv
// Multiply/divide datapath: operand magnitudes, shift-add / restoring-divide
// step, and sign/overflow fix-up into the result registers.
module multdiv_dp
    import multdiv_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_en_i,
    input  logic             step_en_i,
    input  logic             fix_en_i,
    input  logic             op_div_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] result_o,
    output logic             exception_o
);

    localparam int unsigned PW = 2 * WIDTH;

    logic [PW-1:0]    prod_q, prod_d;
    logic [WIDTH-1:0] mag_a_q, mag_a_d, mag_b_q, mag_b_d;
    logic             neg_q, neg_d, divz_q, divz_d;
    op_e              op_q, op_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             exc_q, exc_d;

    logic [WIDTH-1:0] abs_a, abs_b;
    logic [WIDTH:0]   add_sum, rem_shift, rem_diff;
    logic [PW-1:0]    mul_next, div_next, prod_signed;
    logic [WIDTH-1:0] quot_signed;
    logic             mul_ovf, div_ovf;

    // Magnitudes of the incoming operands; the most-negative value maps to 2^(WIDTH-1).
    assign abs_a = a_i[WIDTH-1] ? (~a_i + WIDTH'(1)) : a_i;
    assign abs_b = b_i[WIDTH-1] ? (~b_i + WIDTH'(1)) : b_i;

    // One iteration of shift-add multiply and restoring divide.
    always_comb begin
        add_sum   = {1'b0, prod_q[PW-1:WIDTH]} + {1'b0, (prod_q[0] ? mag_a_q : '0)};
        mul_next  = {add_sum, prod_q[WIDTH-1:1]};
        rem_shift = {prod_q[PW-1:WIDTH], prod_q[WIDTH-1]};
        rem_diff  = rem_shift - {1'b0, mag_b_q};
        if (rem_shift >= {1'b0, mag_b_q}) begin
            div_next = {rem_diff[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};
        end else begin
            div_next = {prod_q[PW-2:0], 1'b0};
        end
    end

    // Sign application and overflow detection for the finished magnitude.
    always_comb begin
        prod_signed = neg_q ? (~prod_q + PW'(1)) : prod_q;
        quot_signed = neg_q ? (~prod_q[WIDTH-1:0] + WIDTH'(1)) : prod_q[WIDTH-1:0];
        mul_ovf     = !((&prod_signed[PW-1:WIDTH-1]) || !(|prod_signed[PW-1:WIDTH-1]));
        div_ovf     = !neg_q && prod_q[WIDTH-1];
    end

    // Next-state selection for all datapath registers.
    always_comb begin
        prod_d   = prod_q;
        mag_a_d  = mag_a_q;
        mag_b_d  = mag_b_q;
        neg_d    = neg_q;
        divz_d   = divz_q;
        op_d     = op_q;
        result_d = result_q;
        exc_d    = exc_q;
        if (load_en_i) begin
            op_d    = op_div_i ? OP_DIV : OP_MULT;
            mag_a_d = abs_a;
            mag_b_d = abs_b;
            neg_d   = a_i[WIDTH-1] ^ b_i[WIDTH-1];
            divz_d  = op_div_i && (b_i == '0);
            prod_d  = op_div_i ? {{WIDTH{1'b0}}, abs_a} : {{WIDTH{1'b0}}, abs_b};
        end else if (step_en_i) begin
            prod_d = (op_q == OP_DIV) ? div_next : mul_next;
        end
        if (fix_en_i) begin
            if (op_q == OP_MULT) begin
                result_d = prod_signed[WIDTH-1:0];
                exc_d    = mul_ovf;
            end else if (divz_q) begin
                result_d = '0;
                exc_d    = 1'b1;
            end else begin
                result_d = quot_signed;
                exc_d    = div_ovf;
            end
        end
    end

    // Datapath register bank.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prod_q   <= '0;
            mag_a_q  <= '0;
            mag_b_q  <= '0;
            neg_q    <= 1'b0;
            divz_q   <= 1'b0;
            op_q     <= OP_MULT;
            result_q <= '0;
            exc_q    <= 1'b0;
        end else begin
            prod_q   <= prod_d;
            mag_a_q  <= mag_a_d;
            mag_b_q  <= mag_b_d;
            neg_q    <= neg_d;
            divz_q   <= divz_d;
            op_q     <= op_d;
            result_q <= result_d;
            exc_q    <= exc_d;
        end
    end

    assign result_o    = result_q;
    assign exception_o = exc_q;

endmodule

// File: rtl/multdiv_ctrl.sv
// Sequential signed multiply/divide controller (IDLE/RUN/FIX/DONE).
// Optional build macro MULTDIV_ABORT_EN: a start seen in RUN or FIX aborts
// the current operation and restarts with the new operands.
module multdiv_ctrl
    import multdiv_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int unsigned CNT_W = cnt_width(WIDTH);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rdy_q, rdy_d, busy_q, busy_d;
    logic             load_en, step_en, fix_en;
    logic             start, op_div, divz_start;
    op_e              op_sel;

    // Multiply wins when both start pulses arrive together.
    assign start      = ctrl_MULT | ctrl_DIV;
    assign op_sel     = ctrl_MULT ? OP_MULT : OP_DIV;
    assign op_div     = (op_sel == OP_DIV);
    assign divz_start = op_div && (data_operandB == '0);

    // Next-state, counter and datapath enables.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load_en = 1'b0;
        step_en = 1'b0;
        fix_en  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load_en = 1'b1;
                    cnt_d   = '0;
                    state_d = divz_start ? FIX : RUN;
                end
            end
            RUN: begin
                step_en = 1'b1;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = FIX;
                end
`ifdef MULTDIV_ABORT_EN
                if (start) begin
                    step_en = 1'b0;
                    load_en = 1'b1;
                    cnt_d   = '0;
                    state_d = divz_start ? FIX : RUN;
                end
`endif
            end
            FIX: begin
                fix_en  = 1'b1;
                state_d = DONE;
`ifdef MULTDIV_ABORT_EN
                if (start) begin
                    fix_en  = 1'b0;
                    load_en = 1'b1;
                    cnt_d   = '0;
                    state_d = divz_start ? FIX : RUN;
                end
`endif
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        rdy_d  = (state_d == DONE);
        busy_d = (state_d != IDLE);
    end

    // State, counter and registered status outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdy_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdy_q   <= rdy_d;
            busy_q  <= busy_d;
        end
    end

    multdiv_dp #(
        .WIDTH(WIDTH)
    ) u_dp (
        .clk_i       (clock),
        .rst_ni      (reset_n),
        .load_en_i   (load_en),
        .step_en_i   (step_en),
        .fix_en_i    (fix_en),
        .op_div_i    (op_div),
        .a_i         (data_operandA),
        .b_i         (data_operandB),
        .result_o    (data_result),
        .exception_o (data_exception)
    );

    assign data_resultRDY = rdy_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Directed bench for multdiv_ctrl (WIDTH=32): vector table plus reset-abort
// and second-start sequences. Also valid with MULTDIV_ABORT_EN defined.
module tb_multdiv_ctrl;

    logic        clock;
    logic        reset_n;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        mult;
        logic        div;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        exc;
        int          lat;
    } vec_t;

    vec_t vecs[14];

    multdiv_ctrl #(.WIDTH(32)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Issue one start, scramble operands afterwards, and check result and latency.
    task automatic do_op(input int idx, input logic m, input logic d,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input logic exp_exc, input int exp_lat);
        int cyc;
        logic [31:0] held;
        ctrl_MULT     = m;
        ctrl_DIV      = d;
        data_operandA = a;
        data_operandB = b;
        @(posedge clock); #1;
        cyc = 1;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
        check($sformatf("v%0d busy", idx), 32'(busy), 32'd1);
        while (!data_resultRDY && cyc < 100) begin
            @(posedge clock); #1;
            cyc++;
        end
        check($sformatf("v%0d latency", idx), 32'(cyc), 32'(exp_lat));
        check($sformatf("v%0d result", idx), data_result, exp_res);
        check($sformatf("v%0d exception", idx), 32'(data_exception), 32'(exp_exc));
        held = data_result;
        @(posedge clock); #1;
        check($sformatf("v%0d rdy_one_cycle", idx), 32'(data_resultRDY), 32'd0);
        check($sformatf("v%0d busy_idle", idx), 32'(busy), 32'd0);
        check($sformatf("v%0d result_held", idx), data_result, exp_res);
        check($sformatf("v%0d held_stable", idx), data_result, held);
    endtask

    initial begin
        int cyc;
        int rdy_seen;

        vecs[0]  = '{1'b1, 1'b0, 32'h0000_0007, 32'hFFFF_FFFA, 32'hFFFF_FFD6, 1'b0, 34};
        vecs[1]  = '{1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1, 34};
        vecs[2]  = '{1'b1, 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 34};
        vecs[3]  = '{1'b0, 1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 1'b0, 34};
        vecs[4]  = '{1'b0, 1'b1, 32'h0000_0005, 32'h0000_0000, 32'h0000_0000, 1'b1, 2};
        vecs[5]  = '{1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 34};
        vecs[6]  = '{1'b1, 1'b1, 32'h0000_0003, 32'h0000_0002, 32'h0000_0006, 1'b0, 34};
        vecs[7]  = '{1'b1, 1'b0, 32'hFFFF_FFFD, 32'hFFFF_FFFC, 32'h0000_000C, 1'b0, 34};
        vecs[8]  = '{1'b0, 1'b1, 32'h0000_0064, 32'h0000_0007, 32'h0000_000E, 1'b0, 34};
        vecs[9]  = '{1'b1, 1'b0, 32'h8000_0000, 32'h0000_0001, 32'h8000_0000, 1'b0, 34};
        vecs[10] = '{1'b0, 1'b1, 32'h0000_0007, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b0, 34};
        vecs[11] = '{1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 34};
        vecs[12] = '{1'b0, 1'b1, 32'h8000_0000, 32'h0000_0001, 32'h8000_0000, 1'b0, 34};
        vecs[13] = '{1'b0, 1'b1, 32'h0000_0003, 32'h0000_0005, 32'h0000_0000, 1'b0, 34};

        reset_n       = 1'b0;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        repeat (2) @(posedge clock);
        #1;
        check("reset result", data_result, 32'd0);
        check("reset exception", 32'(data_exception), 32'd0);
        check("reset rdy", 32'(data_resultRDY), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        reset_n = 1'b1;

        // Table: first start immediately follows reset release.
        for (int i = 0; i < 14; i++) begin
            do_op(i, vecs[i].mult, vecs[i].div, vecs[i].a, vecs[i].b,
                  vecs[i].res, vecs[i].exc, vecs[i].lat);
        end

        // Reset pulsed at iteration 10 of a multiply discards it at once.
        ctrl_MULT     = 1'b1;
        data_operandA = 32'h0000_0007;
        data_operandB = 32'h0000_0009;
        @(posedge clock); #1;
        ctrl_MULT = 1'b0;
        repeat (10) @(posedge clock);
        #1;
        reset_n = 1'b0;
        #1;
        check("midrst result", data_result, 32'd0);
        check("midrst exception", 32'(data_exception), 32'd0);
        check("midrst rdy", 32'(data_resultRDY), 32'd0);
        check("midrst busy", 32'(busy), 32'd0);
        reset_n  = 1'b1;
        rdy_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock); #1;
            if (data_resultRDY) rdy_seen++;
        end
        check("midrst no_rdy", 32'(rdy_seen), 32'd0);
        check("midrst result_zero", data_result, 32'd0);

        // Second start at iteration 5 of 7 x -6 with operands 3 x 2.
        ctrl_MULT     = 1'b1;
        data_operandA = 32'h0000_0007;
        data_operandB = 32'hFFFF_FFFA;
        @(posedge clock); #1;
        cyc = 1;
        ctrl_MULT = 1'b0;
        while (!data_resultRDY && cyc < 100) begin
            if (cyc == 5) begin
                ctrl_MULT     = 1'b1;
                data_operandA = 32'h0000_0003;
                data_operandB = 32'h0000_0002;
            end
            @(posedge clock); #1;
            cyc++;
            ctrl_MULT = 1'b0;
        end
`ifdef MULTDIV_ABORT_EN
        check("restart latency", 32'(cyc), 32'd39);
        check("restart result", data_result, 32'h0000_0006);
`else
        check("restart latency", 32'(cyc), 32'd34);
        check("restart result", data_result, 32'hFFFF_FFD6);
`endif
        check("restart exception", 32'(data_exception), 32'd0);
        @(posedge clock); #1;
        check("restart rdy_one_cycle", 32'(data_resultRDY), 32'd0);
        rdy_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock); #1;
            if (data_resultRDY) rdy_seen++;
        end
        check("restart single_rdy", 32'(rdy_seen), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multdiv_ctrl.md
MULTDIV_CTRL -- requirements
Module: multdiv_ctrl

Interface
REQ-001 Parameter WIDTH, default 32, operand and result width in bits; SHALL be 8..32.
REQ-002 clock  input  1  rising-edge clock; single clock domain.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 data_operandA  input  WIDTH  multiplicand/dividend, two's complement.
REQ-005 data_operandB  input  WIDTH  multiplier/divisor, two's complement.
REQ-006 ctrl_MULT  input  1  start-multiply pulse, sampled on a rising edge.
REQ-007 ctrl_DIV  input  1  start-divide pulse, sampled on a rising edge.
REQ-008 data_result  output  WIDTH  registered result; held until the next start.
REQ-009 data_exception  output  1  registered; qualifies data_result while data_resultRDY is high.
REQ-010 data_resultRDY  output  1  single-cycle completion strobe.
REQ-011 busy  output  1  high in every state except IDLE.

Function
REQ-012 FSM states SHALL be IDLE, RUN, FIX and DONE.
- IDLE -> RUN on a start.
- RUN -> FIX after exactly WIDTH iterations.
- FIX -> DONE.
- DONE -> IDLE unconditionally.
REQ-013 Operands SHALL be captured on the edge that samples a start; later operand changes SHALL have no effect.
REQ-014 If ctrl_MULT and ctrl_DIV are both high in the same cycle, multiply SHALL win.
REQ-015 RUN SHALL convert operands to magnitudes and perform one shift-add (multiply) or one restoring-subtract (divide) step per cycle.
- A log2(WIDTH)+1-bit iteration counter SHALL increment once per step.
REQ-016 FIX SHALL apply the result sign and register data_result and data_exception.
REQ-017 data_resultRDY SHALL be high for exactly one cycle, in DONE, which is WIDTH+2 cycles after the start-sampling edge.
REQ-018 Multiply SHALL return the low WIDTH bits of the signed 2*WIDTH-bit product.
- data_exception=1 when the product does not fit in WIDTH signed bits.
REQ-019 Divide SHALL return the quotient truncated toward zero; the remainder is discarded.
REQ-020 Divide with divisor 0 SHALL skip RUN and go IDLE -> FIX -> DONE.
- Result 0, data_exception=1, data_resultRDY 2 cycles after start.
REQ-021 Divide of most-negative by -1 SHALL return the most-negative value with data_exception=1.
REQ-022 Starts seen while busy SHALL be ignored unless MULTDIV_ABORT_EN is defined (REQ-027).
REQ-023 data_result and data_exception SHALL remain stable from DONE until the FIX of the next operation.

Reset
REQ-024 reset_n low SHALL immediately force the following, independent of clock:
- state IDLE, counter 0, all internal registers 0;
- data_result=0, data_exception=0, data_resultRDY=0, busy=0.
REQ-025 Reset asserted mid-operation SHALL discard that operation; no data_resultRDY SHALL follow.
REQ-026 The first start SHALL be accepted on the first rising edge after reset_n deasserts.

Configuration
REQ-027 Macro MULTDIV_ABORT_EN:
- Defined: a start sampled in RUN or FIX aborts the current operation, captures the new operands and restarts RUN at iteration 0. The aborted operation SHALL produce no data_resultRDY.
- Undefined: starts sampled while busy are dropped. A start in DONE is dropped in both builds.

Structure
REQ-028 Package multdiv_pkg SHALL hold:
- the state enumeration;
- the operation-type enumeration (OP_MULT, OP_DIV);
- the WIDTH default and the counter-width function.
REQ-029 Sub-module multdiv_dp SHALL hold the registers and per-step arithmetic:
- product/remainder register, magnitude registers, sign flags;
- step-enable and load-enable inputs driven by the FSM in multdiv_ctrl.

Verification
REQ-030 The bench SHALL cover these directed scenarios (WIDTH=32):
- MULT 7 x -6 -> data_result=0xFFFFFFD6, exception 0, data_resultRDY exactly 34 cycles after start.
- MULT 0x00010000 x 0x00010000 -> exception 1; MULT 0x7FFFFFFF x 1 -> 0x7FFFFFFF, exception 0.
- DIV -7 / 2 -> 0xFFFFFFFD (-3); DIV 5 / 0 -> 0, exception 1, data_resultRDY 2 cycles after start.
- DIV 0x80000000 / -1 -> 0x80000000, exception 1; ctrl_MULT and ctrl_DIV both high with 3, 2 -> result 6.
- reset_n pulsed low at iteration 10 of a MULT -> all outputs 0 immediately; no data_resultRDY.
- Second start at iteration 5:
  - without MULTDIV_ABORT_EN -> original result, RDY at cycle 34;
  - with MULTDIV_ABORT_EN -> new result, RDY 34 cycles after the second start.
